// File: rtl/byte_to_word_packer_pkg.sv
// Shared definitions for the byte <-> word path: widths, byte-count encoding
// and lane mapping, so the serializer and packer agree on lane numbering.
package byte_to_word_packer_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef logic [1:0] count_t;

  localparam count_t S0 = 2'd0;
  localparam count_t S1 = 2'd1;
  localparam count_t S2 = 2'd2;
  localparam count_t S3 = 2'd3;

  localparam bit LSB_FIRST_DEFAULT = 1'b1;

  // Byte index within a word -> byte lane of the 32-bit word.
  function automatic count_t lane_of(input count_t idx, input bit lsb_first);
    return lsb_first ? idx : count_t'(S3 - idx);
  endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Reassembles a valid/ready byte stream into 32-bit words, with optional
// start-of-word realignment and a one-word output register.
module byte_to_word_packer
  import byte_to_word_packer_pkg::*;
#(
  parameter bit LSB_FIRST = LSB_FIRST_DEFAULT,
  parameter bit SOF_CHECK = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              align_err
);

  count_t              count_q, count_d;
  logic [WORD_W-1:0]   partial_q, partial_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                align_err_q, align_err_d;

  logic                byte_acc;
  logic                word_acc;
  logic                realign;
  count_t              byte_idx;
  count_t              lane;

  // Only the 4th byte can stall, and only while the output word is unconsumed.
  assign in_ready = (count_q != S3) | ~out_valid_q | out_ready;

  always_comb begin
    byte_acc    = in_valid & in_ready;
    word_acc    = out_valid_q & out_ready;
    realign     = SOF_CHECK & in_sof & (count_q != S0);
    byte_idx    = realign ? S0 : count_q;
    lane        = lane_of(byte_idx, LSB_FIRST);

    count_d     = count_q;
    partial_d   = partial_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    align_err_d = 1'b0;

    if (word_acc) begin
      out_valid_d = 1'b0;
    end

    if (byte_acc) begin
      partial_d[{lane, 3'b000} +: BYTE_W] = in_data;
      if (realign) begin
        // Stale lanes are left as don't-care; they are overwritten before completion.
        count_d     = S1;
        align_err_d = 1'b1;
      end else if (count_q == S3) begin
        count_d     = S0;
        out_data_d  = partial_d;
        out_valid_d = 1'b1;
      end else begin
        count_d = count_t'(count_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q     <= S0;
      partial_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      partial_q   <= partial_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      align_err_q <= align_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Directed and randomized checks of byte_to_word_packer; a little-endian and a
// big-endian instance share the same stimulus.
module tb_byte_to_word_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_sof = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_le, out_valid_le, align_err_le;
  logic [31:0] out_data_le;
  logic        in_ready_be, out_valid_be, align_err_be;
  logic [31:0] out_data_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  byte_to_word_packer #(.LSB_FIRST(1'b1), .SOF_CHECK(1'b1)) dut_le (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_ready(in_ready_le), .out_valid(out_valid_le),
    .out_data(out_data_le), .out_ready(out_ready), .align_err(align_err_le)
  );

  byte_to_word_packer #(.LSB_FIRST(1'b0), .SOF_CHECK(1'b1)) dut_be (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_ready(in_ready_be), .out_valid(out_valid_be),
    .out_data(out_data_be), .out_ready(out_ready), .align_err(align_err_be)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid_le !== 1'b0 || out_data_le !== 32'h0 || align_err_le !== 1'b0 || in_ready_le !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b od=%h ae=%b ir=%b, required ov=0 od=00000000 ae=0 ir=1",
               out_valid_le, out_data_le, align_err_le, in_ready_le);
    end
    $display("test_reset: ov=%b od=%h", out_valid_le, out_data_le);
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[i];
      #1;
      vectors++;
      if (in_ready_le !== 1'b1 || out_valid_le !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_pre_%0d: ir=%b ov=%b, required ir=1 ov=0", i, in_ready_le, out_valid_le);
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid_le !== 1'b1 || out_data_le !== 32'h44332211) begin
      miscompares++;
      $display("FAIL basic_word: ov=%b od=%h, required ov=1 od=44332211", out_valid_le, out_data_le);
    end
    $display("test_basic: word %h", out_data_le);
    tick();
    vectors++;
    if (out_valid_le !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_one_cycle: ov=%b, required 0", out_valid_le);
    end
  endtask

  task automatic test_big_endian();
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[i];
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid_be !== 1'b1 || out_data_be !== 32'h11223344) begin
      miscompares++;
      $display("FAIL big_endian_word: ov=%b od=%h, required ov=1 od=11223344", out_valid_be, out_data_be);
    end
    $display("test_big_endian: word %h", out_data_be);
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_data = 8'h08;
    #1;
    vectors++;
    if (in_ready_le !== 1'b0 || out_valid_le !== 1'b1 || out_data_le !== 32'h04030201) begin
      miscompares++;
      $display("FAIL bp_stall: ir=%b ov=%b od=%h, required ir=0 ov=1 od=04030201",
               in_ready_le, out_valid_le, out_data_le);
    end
    tick();
    vectors++;
    if (out_valid_le !== 1'b1 || out_data_le !== 32'h04030201) begin
      miscompares++;
      $display("FAIL bp_hold: ov=%b od=%h, required ov=1 od=04030201", out_valid_le, out_data_le);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready_le !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: ir=%b, required 1", in_ready_le);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid_le !== 1'b1 || out_data_le !== 32'h08070605) begin
      miscompares++;
      $display("FAIL bp_handoff: ov=%b od=%h, required ov=1 od=08070605", out_valid_le, out_data_le);
    end
    $display("test_backpressure: handoff word %h", out_data_le);
  endtask

  task automatic test_realign();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    in_data = 8'hC0; in_sof = 1'b1; tick();
    in_sof = 1'b0;
    vectors++;
    if (align_err_le !== 1'b1) begin
      miscompares++;
      $display("FAIL realign_err: ae=%b, required 1", align_err_le);
    end
    in_data = 8'hC1; tick();
    vectors++;
    if (align_err_le !== 1'b0 || out_valid_le !== 1'b0) begin
      miscompares++;
      $display("FAIL realign_pulse: ae=%b ov=%b, required ae=0 ov=0", align_err_le, out_valid_le);
    end
    in_data = 8'hC2; tick();
    in_data = 8'hC3; tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid_le !== 1'b1 || out_data_le !== 32'hC3C2C1C0) begin
      miscompares++;
      $display("FAIL realign_word: ov=%b od=%h, required ov=1 od=C3C2C1C0", out_valid_le, out_data_le);
    end
    $display("test_realign: word %h", out_data_le);
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'h50 + i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid_le !== 1'b0 || out_data_le !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: ov=%b od=%h, required ov=0 od=00000000", out_valid_le, out_data_le);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 8'hDE; tick();
    in_data = 8'hAD; tick();
    in_data = 8'hBE; tick();
    in_data = 8'hEF; tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid_le !== 1'b1 || out_data_le !== 32'hEFBEADDE) begin
      miscompares++;
      $display("FAIL post_reset_word: ov=%b od=%h, required ov=1 od=EFBEADDE", out_valid_le, out_data_le);
    end
    $display("test_async_reset: word %h", out_data_le);
  endtask

  // Random handshakes against a byte-level scoreboard; expected words are
  // built from the accepted byte stream, and at most one word is ever pending.
  task automatic test_random_stream();
    logic [31:0] pending [$];
    logic [31:0] asm_word;
    int          cnt;
    int          bytes_in;
    int          words_out;
    int          cycles;
    logic        exp_ready;
    logic        b_acc, w_acc;
    do_reset();
    asm_word = '0; cnt = 0; bytes_in = 0; words_out = 0; cycles = 0;
    while (bytes_in < 10000 && cycles < 60000) begin
      vectors++;
      if (out_valid_le !== (pending.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_ov cyc %0d: ov=%b, required %b", cycles, out_valid_le, pending.size() != 0);
      end
      if (pending.size() != 0) begin
        vectors++;
        if (out_data_le !== pending[0]) begin
          miscompares++;
          $display("FAIL rand_data cyc %0d: od=%h, required %h", cycles, out_data_le, pending[0]);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = !((cnt == 3) && (pending.size() != 0) && !out_ready);
      vectors++;
      if (in_ready_le !== exp_ready) begin
        miscompares++;
        $display("FAIL rand_ready cyc %0d: ir=%b, required %b", cycles, in_ready_le, exp_ready);
      end
      b_acc = in_valid && exp_ready;
      w_acc = (pending.size() != 0) && out_ready;
      if (w_acc) begin
        void'(pending.pop_front());
        words_out++;
      end
      if (b_acc) begin
        asm_word[8*cnt +: 8] = in_data;
        bytes_in++;
        if (cnt == 3) begin
          pending.push_back(asm_word);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bytes_in < 10000) begin
      miscompares++;
      $display("FAIL rand_budget: %0d bytes accepted, required 10000", bytes_in);
    end
    $display("test_random_stream: %0d bytes, %0d words consumed, %0d cycles", bytes_in, words_out, cycles);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_big_endian();
    test_backpressure();
    test_realign();
    test_async_reset();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
